// File: rtl/seed_pkg.sv
// Shared constants for the SEED S-box datapath: FSM encoding, GF(2^8) field,
// exponents and the affine layer (matrix rows are output bits, bit c = input bit c).
package seed_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_SQR  = 3'd1;
  localparam state_t ST_MUL  = 3'd2;
  localparam state_t ST_AFF  = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  localparam logic [8:0] GF_POLY = 9'h163;

  localparam logic [7:0] EXP_S1 = 8'hF7;
  localparam logic [7:0] EXP_S2 = 8'hFB;

  localparam logic [7:0] AFF_C1 = 8'hA9;
  localparam logic [7:0] AFF_C2 = 8'h38;

  // Index 7 first: AFF_Ax[r] selects the input bits XORed into output bit r.
  localparam logic [7:0][7:0] AFF_A1 = {8'h8A, 8'hFE, 8'h85, 8'h42,
                                        8'h45, 8'h21, 8'h88, 8'h14};
  localparam logic [7:0][7:0] AFF_A2 = {8'h45, 8'h85, 8'hFE, 8'h21,
                                        8'h8A, 8'h88, 8'h42, 8'h14};

endpackage

// File: rtl/x_pow_n.sv
// Combinational GF(2^8) multiplier over x^8+x^6+x^5+x+1, shared by every
// squaring and multiply step of the S-box exponentiation.
module x_pow_n
  import seed_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [14:0] prod;

  always_comb begin
    prod = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod ^ ({7'b0, a} << i);
    end
    // Fold the high bits back down, top bit first, so each fold stays in range.
    for (int i = 14; i >= 8; i--) begin
      if (prod[i]) prod = prod ^ ({6'b0, GF_POLY} << (i - 8));
    end
    p = prod[7:0];
  end

endmodule

// File: rtl/seed_sbox_ser.sv
// Serial SEED S-box: constant-time square-and-multiply of x^247 / x^251 on one
// shared GF(2^8) multiplier, followed by the affine layer; 19 cycles per result.
module seed_sbox_ser
  import seed_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout
);

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] xr_q, xr_d;
  logic       sr_q, sr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] dout_q, dout_d;

  logic [7:0]      exp_sel;
  logic            exp_bit;
  logic [7:0]      mul_b;
  logic [7:0]      mul_p;
  logic [7:0][7:0] aff_mat;
  logic [7:0]      aff_y;

  assign exp_sel = sr_q ? EXP_S2 : EXP_S1;
  assign exp_bit = exp_sel[idx_q];

  // Multiplying by 1 on a clear exponent bit keeps the timing data-independent.
  assign mul_b = (state_q == ST_SQR) ? acc_q : (exp_bit ? xr_q : 8'h01);

  x_pow_n u_mul (
    .a (acc_q),
    .b (mul_b),
    .p (mul_p)
  );

  assign aff_mat = sr_q ? AFF_A2 : AFF_A1;

  always_comb begin
    aff_y = '0;
    for (int r = 0; r < 8; r++) begin
      aff_y[r] = ^(aff_mat[r] & acc_q);
    end
    aff_y = aff_y ^ (sr_q ? AFF_C2 : AFF_C1);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    xr_d    = xr_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          xr_d    = din;
          sr_d    = sel;
          acc_d   = 8'h01;
          idx_d   = 3'd7;
          state_d = ST_SQR;
        end
      end
      ST_SQR: begin
        acc_d   = mul_p;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        acc_d = mul_p;
        if (idx_q == 3'd0) begin
          state_d = ST_AFF;
        end else begin
          idx_d   = idx_q - 3'd1;
          state_d = ST_SQR;
        end
      end
      ST_AFF: begin
        dout_d  = aff_y;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= 8'h01;
      xr_q    <= 8'h00;
      sr_q    <= 1'b0;
      idx_q   <= 3'd7;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      xr_q    <= xr_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign dout = dout_q;

endmodule

// File: tb/tb_seed_sbox_ser.sv
// Self-checking bench for seed_sbox_ser: directed S-box vectors, full sweep
// against a reference model, and the start-ignore / abort / back-to-back cases.
module tb_seed_sbox_ser;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic [7:0] dout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seed_sbox_ser dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sel   (sel),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  typedef struct {
    logic       sel;
    logic [7:0] din;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[12];

  // Affine matrices stored as columns: entry c is the image of input bit c.
  localparam logic [7:0][7:0] COLS_A1 = {8'hE2, 8'h58, 8'h44, 8'h41,
                                         8'hC2, 8'h69, 8'hD0, 8'h2C};
  localparam logic [7:0][7:0] COLS_A2 = {8'h6C, 8'hA2, 8'h30, 8'h21,
                                         8'h2C, 8'hE1, 8'h2A, 8'hD0};

  function automatic logic [7:0] gf_mul_ref(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] r = 8'h00;
    logic       carry;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) r = r ^ a;
      b     = b >> 1;
      carry = a[7];
      a     = a << 1;
      if (carry) a = a ^ 8'h63;
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic s, input logic [7:0] x);
    int         n = s ? 251 : 247;
    logic [7:0] p = 8'h01;
    logic [7:0] y = 8'h00;
    for (int k = 0; k < n; k++) p = gf_mul_ref(p, x);
    for (int c = 0; c < 8; c++) begin
      if (p[c]) y = y ^ (s ? COLS_A2[c] : COLS_A1[c]);
    end
    return y ^ (s ? 8'h38 : 8'hA9);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // One request; optionally re-pulses start with other operands at cycle pulse_at.
  task automatic applyStimulus(input logic s, input logic [7:0] x, input int pulse_at,
                               output logic [7:0] res, output int lat, output logic busy_ok);
    busy_ok = 1'b1;
    lat     = 0;
    res     = 8'h00;
    @(negedge clk);
    start = 1'b1;
    sel   = s;
    din   = x;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == pulse_at);
      sel   = ~s;
      din   = (n == pulse_at) ? (x ^ 8'h5A) : ~x;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = n;
        res = dout;
        break;
      end
    end
    if (lat == 0) res = dout;
    @(negedge clk);
    start = 1'b0;
    if (busy || done) busy_ok = 1'b0;
  endtask

  initial begin
    logic [7:0] res;
    int         lat;
    logic       bok;
    logic       seen_done;
    int         prev;
    int         k;

    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    din   = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_dout", dout, 8'h00);
    rst = 1'b0;

    vecs[0]  = '{1'b0, 8'h00, 8'hA9};
    vecs[1]  = '{1'b0, 8'h01, 8'h85};
    vecs[2]  = '{1'b1, 8'h00, 8'h38};
    vecs[3]  = '{1'b1, 8'h01, 8'hE8};
    vecs[4]  = '{1'b0, 8'h02, 8'hD6};
    vecs[5]  = '{1'b0, 8'h04, 8'h54};
    vecs[6]  = '{1'b0, 8'h08, 8'h5D};
    vecs[7]  = '{1'b1, 8'h02, 8'h2D};
    vecs[8]  = '{1'b1, 8'h04, 8'hCF};
    vecs[9]  = '{1'b1, 8'h10, 8'hC3};
    vecs[10] = '{1'b0, 8'hFB, 8'h79};
    vecs[11] = '{1'b1, 8'hB4, 8'h12};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].din, 0, res, lat, bok);
      checkOutput($sformatf("vec%0d_dout", i), res, vecs[i].exp_dout);
      checkOutput($sformatf("vec%0d_latency", i), lat, 18);
      checkOutput($sformatf("vec%0d_busy", i), bok, 1);
    end

    repeat (5) @(negedge clk);
    checkOutput("dout_hold", dout, 8'h12);

    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 256; x++) begin
        applyStimulus(s[0], x[7:0], 0, res, lat, bok);
        checkOutput($sformatf("sweep_s%0d_x%02h_dout", s + 1, x), res, sbox_ref(s[0], x[7:0]));
        checkOutput($sformatf("sweep_s%0d_x%02h_latency", s + 1, x), lat, 18);
        checkOutput($sformatf("sweep_s%0d_x%02h_busy", s + 1, x), bok, 1);
      end
    end

    applyStimulus(1'b0, 8'h02, 5, res, lat, bok);
    checkOutput("ignore_start_dout", res, 8'hD6);
    checkOutput("ignore_start_latency", lat, 18);
    checkOutput("ignore_start_idle_after", bok, 1);

    @(negedge clk);
    start     = 1'b1;
    sel       = 1'b1;
    din       = 8'h01;
    seen_done = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen_done = 1'b1;
      if (n == 9) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_no_done_before", seen_done, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_dout", dout, 8'h00);
    applyStimulus(1'b1, 8'h01, 0, res, lat, bok);
    checkOutput("after_abort_dout", res, 8'hE8);
    checkOutput("after_abort_latency", lat, 18);

    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    sel   = 1'b0;
    din   = 8'h01;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rst_beats_start_busy", busy, 0);
    checkOutput("rst_beats_start_dout", dout, 8'h00);

    @(negedge clk);
    start = 1'b1;
    sel   = 1'b0;
    din   = 8'h04;
    prev  = 0;
    k     = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        checkOutput($sformatf("b2b%0d_dout", k), dout, 8'h54);
        checkOutput($sformatf("b2b%0d_spacing", k), n - prev, (k == 0) ? 18 : 19);
        prev = n;
        k++;
      end
    end
    checkOutput("b2b_result_count", k, 3);
    start = 1'b0;
    for (int n = 0; n < 40 && busy; n++) @(negedge clk);
    checkOutput("b2b_drain_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seed_sbox_ser.md
SEED_SBOX_SER -- requirements
Module: seed_sbox_ser

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL: start  input  1  request; sampled only in IDLE.
REQ-004 SHALL: sel  input  1  0 = S-box S1 (exponent 247, 0xF7); 1 = S-box S2 (exponent 251, 0xFB); captured with start.
REQ-005 SHALL: din  input  8  S-box input byte x; captured with start.
REQ-006 SHALL: busy  output  1  high while a computation is in progress.
REQ-007 SHALL: done  output  1  one-cycle pulse; dout valid in the same cycle.
REQ-008 SHALL: dout  output  8  S-box result; holds its value until the next accepted start.

Function
REQ-009 SHALL: compute S1(x) = A1·x^247 xor 0xA9 and S2(x) = A2·x^251 xor 0x38 over GF(2^8) mod x^8+x^6+x^5+x+1 (0x163).
- A1 and A2 are the SEED affine matrices.
REQ-010 SHALL: use exactly one combinational GF(2^8) multiplier, time-shared over all exponentiation steps; no second multiplier or lookup table.
REQ-011 SHALL: implement FSM states IDLE, SQR, MUL, AFF, DONE, encoded per the shared package.
REQ-012 SHALL: in IDLE with start=1 at edge T, latch din into xr and sel into sr, set acc=0x01, bit index=7, and move to SQR.
REQ-013 SHALL: in SQR, set acc <= acc·acc, then go to MUL.
REQ-014 SHALL: in MUL, set acc <= acc·xr if exponent bit[index]=1, else acc <= acc·0x01 (fixed timing regardless of operand).
- If index=0, go to AFF; otherwise decrement index and go to SQR.
REQ-015 SHALL: exponentiation take exactly 16 cycles (8 SQR/MUL pairs, MSB first), independent of din and sel.
REQ-016 SHALL: in AFF, load dout <= A(sr)·acc xor C(sr) (affine matrix and constant selected by sr), then go to DONE.
REQ-017 SHALL: in DONE, assert done=1, then return to IDLE.
REQ-018 SHALL: have fixed latency: start accepted at edge T gives done=1 in the cycle after edge T+17.
- busy=1 for cycles T+1 through T+18 inclusive.
- busy=0 in the done cycle's successor.
REQ-019 SHALL: ignore start while busy=1; din and sel changes mid-operation have no effect.
REQ-020 SHALL: accept a start asserted in the cycle after DONE (back-to-back throughput one result per 19 cycles).
REQ-021 SHALL: map x=0 to 0^n=0, so dout=0xA9 (S1) or 0x38 (S2); no special-case logic.

Reset
REQ-022 SHALL: rst=1 force state=IDLE, busy=0, done=0, dout=0x00, acc=0x01, xr=0x00, sr=0, index=7 at the next edge.
REQ-023 SHALL: rst asserted mid-operation abort the computation with no done pulse; rst overrides a simultaneous start.

Structure
REQ-024 SHALL: place in shared package seed_pkg:
- FSM state encoding;
- GF polynomial constant 0x163;
- exponents 0xF7/0xFB;
- affine matrices A1, A2 (8 rows of 8 bits each);
- constants 0xA9/0x38.
REQ-025 SHALL: instantiate the team's existing GF(2^8) multiplier x_pow_n as the single sub-module, with operand muxes driven by state.
REQ-026 SHALL: implement the affine transform as combinational logic inside seed_sbox_ser (no additional module).

Verification
REQ-027 SHALL: start, sel=0, din=0x00 -> done after 18 cycles, dout=0xA9.
REQ-028 SHALL: sel=0, din=0x01 -> dout=0x85; sel=1, din=0x00 -> dout=0x38; sel=1, din=0x01 -> dout=0xE8.
REQ-029 SHALL: sweep all 256 inputs for both sel values -> dout matches the golden SEED S1/S2 tables, done timing identical every run.
REQ-030 SHALL: start pulse at cycle 5 of a run with different din/sel -> ignored, result equals the original request.
REQ-031 SHALL: rst at cycle 9 of a run -> no done, busy=0, dout=0x00 next cycle; a fresh start then completes correctly.
REQ-032 SHALL: start held high continuously -> back-to-back results every 19 cycles, each correct.
